// File: rtl/alu_sel_pkg.sv
// Shared opcode numbering and skid-buffer state type for the ALU result selector.
// Parity variant is enabled by defining ALU_SEL_PARITY_EN.
package alu_sel_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SHL  = 2;
    localparam int OP_SHR  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_NOT  = 7;
    localparam int OP_EQ   = 8;
    localparam int OP_GT   = 9;
    localparam int OP_LT   = 10;
    localparam int OP_MAX  = 11;
    localparam int OP_KR   = 12;

    localparam int NUM_OPS = 13;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_result_sel_if.sv
// Valid/ready bundle between the result units and the ALU result register.
// out_par exists only when ALU_SEL_PARITY_EN is defined.
interface alu_result_sel_if #(
    parameter int NCH  = 13,
    parameter int W    = 4,
    parameter int SELW = 4,
    parameter int ECW  = 8
);
    logic [NCH*W-1:0] in_data;
    logic [SELW-1:0]  in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     out_data;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;
    logic [ECW-1:0]   err_cnt;
`ifdef ALU_SEL_PARITY_EN
    logic             out_par;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid,
        input  err_cnt, out_par
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid,
        output err_cnt, out_par
    );
`else
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid,
        input  err_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid,
        output err_cnt
    );
`endif

endinterface

// File: rtl/alu_sel_skid.sv
// Generic 2-entry skid buffer: main entry drives the output, skid holds overflow.
// All handshake outputs are registered.
module alu_sel_skid
    import alu_sel_pkg::*;
#(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_beat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_beat
);

    skid_state_e   state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          acc;
    logic          pop;

    assign acc = in_valid & in_ready_q;
    assign pop = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    main_d  = in_beat;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    main_d  = in_beat;
                end else if (acc) begin
                    state_d = FULL;
                    skid_d  = in_beat;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain can happen
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_beat  = main_q;

endmodule

// File: rtl/alu_result_sel.sv
// Registered ALU result selector: decodes the opcode, buffers (result, err).
// Define ALU_SEL_PARITY_EN to carry an even-parity bit with each beat.
module alu_result_sel
    import alu_sel_pkg::*;
#(
    parameter int NCH  = NUM_OPS,
    parameter int W    = 4,
    parameter int SELW = 4,
    parameter int ECW  = 8
) (
    input logic             clk,
    input logic             rst,
    alu_result_sel_if.slave bus
);

`ifdef ALU_SEL_PARITY_EN
    localparam int PW = W + 2;
`else
    localparam int PW = W + 1;
`endif

    logic           legal;
    logic [W-1:0]   res;
    logic [PW-1:0]  beat_in;
    logic [PW-1:0]  beat_out;
    logic           in_ready;
    logic           acc;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        res   = '0;
        legal = (int'(bus.in_sel) < NCH);
        for (int i = 0; i < NCH; i++) begin
            if (bus.in_sel == SELW'(i)) begin
                res = bus.in_data[i*W +: W];
            end
        end
    end

    // Illegal selects leave res at zero, so their parity is zero too
`ifdef ALU_SEL_PARITY_EN
    assign beat_in = {^res, ~legal, res};
`else
    assign beat_in = {~legal, res};
`endif

    alu_sel_skid #(
        .PW (PW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .in_beat   (beat_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_beat  (beat_out)
    );

    assign acc = bus.in_valid & in_ready;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (acc && !legal && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ECW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.out_data = beat_out[W-1:0];
    assign bus.out_err  = beat_out[W];
    assign bus.err_cnt  = err_cnt_q;
`ifdef ALU_SEL_PARITY_EN
    assign bus.out_par  = beat_out[W+1];
`endif

endmodule

// File: tb/tb_alu_result_sel.sv
// Bench for alu_result_sel: vector table, directed corner sequences, random traffic.
// Reference model is a beat queue plus saturating counters.
module tb_alu_result_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_result_sel_if #(.NCH(13), .W(4), .SELW(4), .ECW(8)) b0 ();
    alu_result_sel_if #(.NCH(13), .W(4), .SELW(4), .ECW(2)) b1 ();

    assign b1.in_data   = b0.in_data;
    assign b1.in_sel    = b0.in_sel;
    assign b1.in_valid  = b0.in_valid;
    assign b1.out_ready = b0.out_ready;

    alu_result_sel #(.NCH(13), .W(4), .SELW(4), .ECW(8)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    alu_result_sel #(.NCH(13), .W(4), .SELW(4), .ECW(2)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    typedef struct {
        logic [3:0] d;
        logic       e;
    } beat_t;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] ch;
        logic [3:0] ed;
        logic       ee;
    } vec_t;

    beat_t      q[$];
    logic [3:0] got[$];
    int         ecnt;
    int         ecnt1;
    int         errors = 0;
    int         checks = 0;
    vec_t       tbl[6];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [51:0] pat(int sel, logic [3:0] ch);
        logic [51:0] v;
        for (int k = 0; k < 13; k++) v[k*4 +: 4] = 4'(15 - k);
        if (sel < 13) v[sel*4 +: 4] = ch;
        return v;
    endfunction

    function automatic logic [51:0] ramp();
        logic [51:0] v;
        for (int k = 0; k < 13; k++) v[k*4 +: 4] = 4'(k);
        return v;
    endfunction

    task automatic check_all();
        chk("out_valid", 32'(b0.out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(b0.in_ready), 32'(q.size() < 2));
        chk("err_cnt", 32'(b0.err_cnt), 32'(ecnt));
        chk("err_cnt_ecw2", 32'(b1.err_cnt), 32'(ecnt1));
        if (q.size() > 0) begin
            chk("out_data", 32'(b0.out_data), 32'(q[0].d));
            chk("out_err", 32'(b0.out_err), 32'(q[0].e));
`ifdef ALU_SEL_PARITY_EN
            chk("out_par", 32'(b0.out_par), 32'(^q[0].d));
`endif
        end
    endtask

    task automatic cycle();
        bit         acc;
        bit         pop;
        logic       e;
        logic [3:0] d;
        int         s;
        s   = int'(b0.in_sel);
        pop = (q.size() > 0) && b0.out_ready;
        acc = b0.in_valid && (q.size() < 2);
        e   = (s >= 13);
        d   = e ? 4'h0 : 4'((b0.in_data >> (s * 4)) & 52'hF);
        if (b0.out_valid && b0.out_ready) got.push_back(b0.out_data);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back('{d: d, e: e});
            if (e) begin
                if (ecnt < 255) ecnt++;
                if (ecnt1 < 3) ecnt1++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        ecnt  = 0;
        ecnt1 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int sel, logic [51:0] data, bit v, bit r);
        b0.in_sel    = 4'(sel);
        b0.in_data   = data;
        b0.in_valid  = v;
        b0.out_ready = r;
    endtask

    initial begin
        tbl[0] = '{sel: 4'd5,  ch: 4'hA, ed: 4'hA, ee: 1'b0};
        tbl[1] = '{sel: 4'd0,  ch: 4'h3, ed: 4'h3, ee: 1'b0};
        tbl[2] = '{sel: 4'd12, ch: 4'hF, ed: 4'hF, ee: 1'b0};
        tbl[3] = '{sel: 4'd13, ch: 4'h7, ed: 4'h0, ee: 1'b1};
        tbl[4] = '{sel: 4'd15, ch: 4'h9, ed: 4'h0, ee: 1'b1};
        tbl[5] = '{sel: 4'd7,  ch: 4'h0, ed: 4'h0, ee: 1'b0};

        drive(0, '0, 1'b0, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(b0.out_valid), 0);
        chk("rst_in_ready", 32'(b0.in_ready), 1);
        chk("rst_out_data", 32'(b0.out_data), 0);
        chk("rst_out_err", 32'(b0.out_err), 0);
        chk("rst_err_cnt", 32'(b0.err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            drive(int'(tbl[i].sel), pat(int'(tbl[i].sel), tbl[i].ch), 1'b1, 1'b1);
            cycle();
            chk("tbl_valid", 32'(b0.out_valid), 1);
            chk("tbl_data", 32'(b0.out_data), 32'(tbl[i].ed));
            chk("tbl_err", 32'(b0.out_err), 32'(tbl[i].ee));
            b0.in_valid = 1'b0;
            cycle();
            chk("tbl_idle", 32'(b0.out_valid), 0);
        end

        for (int i = 0; i < 13; i++) begin
            drive(i, ramp(), 1'b1, 1'b1);
            cycle();
            chk("stream_data", 32'(b0.out_data), i);
            chk("stream_ready", 32'(b0.in_ready), 1);
        end
        b0.in_valid = 1'b0;
        cycle();

        drive(1, ramp(), 1'b1, 1'b0);
        cycle();
        b0.in_sel = 4'd2;
        cycle();
        chk("bp_ready_drop", 32'(b0.in_ready), 0);
        b0.in_sel = 4'd3;
        cycle();
        chk("bp_hold_data", 32'(b0.out_data), 1);
        chk("bp_hold_ready", 32'(b0.in_ready), 0);
        got.delete();
        b0.out_ready = 1'b1;
        cycle();
        cycle();
        b0.in_valid = 1'b0;
        cycle();
        cycle();
        chk("bp_count", 32'(got.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk("bp_order", 32'(got[i]), i + 1);
        end

        do_reset();
        drive(13, ramp(), 1'b1, 1'b1);
        cycle();
        b0.in_sel = 4'd15;
        cycle();
        chk("ill_data", 32'(b0.out_data), 0);
        chk("ill_err", 32'(b0.out_err), 1);
        b0.in_valid = 1'b0;
        cycle();
        chk("ill_cnt2", 32'(b0.err_cnt), 2);
        b0.in_valid = 1'b1;
        b0.in_sel   = 4'd14;
        repeat (3) cycle();
        b0.in_valid = 1'b0;
        cycle();
        chk("ill_cnt5", 32'(b0.err_cnt), 5);
        chk("ill_sat_ecw2", 32'(b1.err_cnt), 3);

        drive(14, ramp(), 1'b1, 1'b0);
        cycle();
        b0.in_sel = 4'd4;
        cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 32'(b0.out_valid), 0);
        chk("arst_ready", 32'(b0.in_ready), 1);
        chk("arst_err_cnt", 32'(b0.err_cnt), 0);
        drive(0, '0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        repeat (3) cycle();
        chk("arst_no_stale", 32'(got.size()), 0);

        for (int n = 0; n < 400; n++) begin
            drive(int'($urandom_range(0, 15)),
                  {20'($urandom), $urandom},
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0));
            cycle();
        end
        drive(0, '0, 1'b0, 1'b1);
        repeat (3) cycle();

`ifdef ALU_SEL_PARITY_EN
        do_reset();
        drive(3, pat(3, 4'b0111), 1'b1, 1'b1);
        cycle();
        chk("par_odd", 32'(b0.out_par), 1);
        b0.in_data = pat(3, 4'b0110);
        cycle();
        chk("par_even", 32'(b0.out_par), 0);
        b0.in_sel = 4'd13;
        cycle();
        chk("par_illegal", 32'(b0.out_par), 0);
        b0.in_valid = 1'b0;
        cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
